uart_wb_bridge: RTL
===================

Name: uart_wb_bridge

Overview:
- UART-to-Wishbone master bridge. Sits directly upstream of the user-area byte-scratch-memory Wishbone slave.
- Lets an external host on the IO pads write and read single memory bytes over a 2-wire serial link.
- Decodes 3/4-byte command frames, issues one Wishbone classic cycle per frame, and returns a 1-byte response on TX.

Parameters:
- BAUD_DIV, 104, clk cycles per UART bit (>=4).
- ADDR_W, 9, address bits forwarded to the slave; higher address bits are forced to 0.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- uart_rx_i  in  1  serial input, idle high, asynchronous to clk
- uart_tx_o  out  1  serial output, idle high
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  byte address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge
- busy_o  out  1  high whenever the command FSM is not in IDLE
- frame_err_o  out  1  one-cycle pulse on a UART stop-bit error

Behaviour:
Reset values:
- uart_tx_o=1.
- All wbm_* outputs 0.
- busy_o=0, frame_err_o=0.
- FSM=IDLE; RX and TX idle; bit counters cleared.
- Reset mid-frame or mid-cycle aborts immediately with no response.

RX:
- 2-flop synchroniser on uart_rx_i.
- Start condition: synchronised falling edge while RX idle.
- Sample start bit at BAUD_DIV/2 cycles after the edge. If it reads high, treat as a glitch and return RX to idle.
- Then sample 8 data bits LSB-first, followed by the stop bit, each BAUD_DIV cycles apart.
- Stop bit = 1: produce a one-cycle rx_valid with the byte.
- Stop bit = 0: pulse frame_err_o, discard the byte, and force the command FSM to IDLE.

TX:
- Frame = 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), each held BAUD_DIV cycles.
- Loaded only from the command FSM.

Command FSM states:
- IDLE: byte 0x57 ('W') -> ADDR_HI with op=write; byte 0x52 ('R') -> ADDR_HI with op=read; any other byte is ignored.
- ADDR_HI: next byte -> addr[15:8].
- ADDR_LO: next byte -> addr[7:0]. Then write -> DATA, read -> WB_REQ.
- DATA: next byte -> wdata, then -> WB_REQ.
- WB_REQ:
  - Assert cyc and stb together on entry and hold them until wbm_ack_i=1.
  - In the ack cycle, deassert cyc and stb on the next edge. Never hold stb for more than one cycle after ack.
  - wbm_adr_o = {zeros, addr[ADDR_W-1:0]}.
  - wbm_we_o = op.
  - Write: wbm_sel_o=4'b0001, wbm_dat_o={4{wdata}}.
  - Read: wbm_sel_o=4'b0000, wbm_dat_o=0; capture wbm_dat_i[7:0] on the ack cycle.
  - After ack -> RESP.
- RESP: load TX with 0x4B ('K') for a write, or the captured byte for a read -> TX_WAIT.
- TX_WAIT: stay until the TX stop bit completes -> IDLE.

Other rules:
- Bytes received in WB_REQ, RESP or TX_WAIT are discarded.
- Latency from stop-bit sample of the last frame byte to cyc rising: 1 clk.
- Latency from ack to TX start bit: 2 clk.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WB_REQ.
  - If 255 cycles pass without ack, drop cyc/stb and go to RESP with response byte 0xEE (read or write).
  - A late ack after the abort is ignored.
- Undefined: WB_REQ waits indefinitely for ack.

Test Plan (BAUD_DIV=4, single-cycle-ack memory model):
- Write then read back: send 57 01 23 A5 -> one WB write, adr=0x123, sel=0001, dat=A5A5A5A5, TX returns 4B. Then send 52 01 23 -> WB read at 0x123, TX returns A5.
- Address masking: write 57 FF 05 3C -> adr=0x105. Then read 52 01 05 -> TX returns 3C.
- Framing error: corrupt the stop bit of the ADDR_LO byte of a 'W' frame -> frame_err_o pulses once, no WB cycle, busy_o falls. Then a valid 52 00 00 frame completes normally.
- Noise handling: unknown byte 0x00 in IDLE, plus a 1-cycle low glitch on rx -> no state change, busy_o stays 0.
- Reset mid-cycle: assert reset while cyc=1 with ack held off -> next clk all wbm_* = 0 and uart_tx_o=1; no TX byte emitted.
- Timeout (WB_TIMEOUT_EN defined, ack tied 0): send 52 00 10 -> cyc drops after 255 cycles, TX returns EE. Without the macro, cyc stays high for 1000+ cycles.

Source files
------------

// File: rtl/uart_wb_bridge_if.sv
// Wishbone classic master-side bus bundle for uart_wb_bridge.
interface uart_wb_bridge_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone master bridge: decodes 'W' hi lo data / 'R' hi lo frames,
// runs one Wishbone classic cycle per frame and answers with one TX byte.
// Optional build macro WB_TIMEOUT_EN: abort an unacknowledged cycle after
// 255 clocks and answer 0xEE; without it the bridge waits for ack forever.
// ADDR_W is expected to be below 16 (upper address bits are dropped).
module uart_wb_bridge #(
  parameter int unsigned BAUD_DIV = 104,
  parameter int unsigned ADDR_W   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             uart_rx_i,
  output logic             uart_tx_o,
  uart_wb_bridge_if.master wbm,
  output logic             busy_o,
  output logic             frame_err_o
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;
`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] RESP_TO   = 8'hEE;
`endif

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WB_REQ, S_RESP, S_TX_WAIT
  } cmd_state_t;

  // RX path state
  logic             rx_meta, rx_s, rx_d;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_valid;

  // TX path state
  logic             tx_busy;
  logic             tx_load;
  logic             tx_done;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [8:0]       tx_shift;

  // Command FSM state
  cmd_state_t       state;
  logic             op_write;
  logic [15:0]      addr_q;
  logic [7:0]       resp_q;
  logic [15:0]      lo_addr;
`ifdef WB_TIMEOUT_EN
  logic [7:0]       to_cnt;
`endif

  // Address formed with the low byte currently being received
  assign lo_addr = {addr_q[15:8], rx_shift};

  logic unused_ok;
  assign unused_ok = &{1'b0, wbm.wbm_dat_i[31:8], addr_q[15:ADDR_W], lo_addr[15:ADDR_W]};

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // UART receiver: mid-bit sampling, glitch rejection, stop-bit check
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_valid    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err_o <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_d && !rx_s) begin
            rx_state <= R_START;
            rx_cnt   <= CNT_W'(BAUD_DIV / 2 - 1);
          end
        end
        R_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end else if (rx_s) begin
            rx_state <= R_IDLE;
          end else begin
            rx_state <= R_DATA;
            rx_cnt   <= CNT_W'(BAUD_DIV - 1);
            rx_bit   <= '0;
          end
        end
        R_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end else begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= CNT_W'(BAUD_DIV - 1);
            if (rx_bit == 3'd7) begin
              rx_state <= R_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end
        end
        R_STOP: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end else begin
            rx_state <= R_IDLE;
            if (rx_s) begin
              rx_valid <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // UART transmitter: start, 8 data bits LSB-first, stop; pulses tx_done at the end
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_tx_o <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '1;
    end else begin
      tx_done <= 1'b0;
      if (tx_busy) begin
        if (tx_cnt != '0) begin
          tx_cnt <= tx_cnt - CNT_W'(1);
        end else begin
          tx_cnt <= CNT_W'(BAUD_DIV - 1);
          if (tx_bit == 4'd9) begin
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
            uart_tx_o <= 1'b1;
          end else begin
            uart_tx_o <= tx_shift[0];
            tx_shift  <= {1'b1, tx_shift[8:1]};
            tx_bit    <= tx_bit + 4'd1;
          end
        end
      end else if (tx_load) begin
        tx_busy   <= 1'b1;
        tx_shift  <= {1'b1, resp_q};
        uart_tx_o <= 1'b0;
        tx_cnt    <= CNT_W'(BAUD_DIV - 1);
        tx_bit    <= '0;
      end
    end
  end

  // Command FSM: frame decode, Wishbone cycle, response hand-off to TX
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      op_write      <= 1'b0;
      addr_q        <= '0;
      resp_q        <= '0;
      tx_load       <= 1'b0;
      busy_o        <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_sel_o <= '0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
`ifdef WB_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      tx_load <= 1'b0;
`ifdef WB_TIMEOUT_EN
      if (state != S_WB_REQ) begin
        to_cnt <= '0;
      end
`endif
      if (frame_err_o) begin
        // A broken byte abandons whatever the FSM was doing
        state         <= S_IDLE;
        busy_o        <= 1'b0;
        wbm.wbm_cyc_o <= 1'b0;
        wbm.wbm_stb_o <= 1'b0;
        wbm.wbm_we_o  <= 1'b0;
        wbm.wbm_sel_o <= '0;
        wbm.wbm_adr_o <= '0;
        wbm.wbm_dat_o <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_valid && (rx_shift == CMD_WRITE || rx_shift == CMD_READ)) begin
              op_write <= (rx_shift == CMD_WRITE);
              state    <= S_ADDR_HI;
              busy_o   <= 1'b1;
            end
          end
          S_ADDR_HI: begin
            if (rx_valid) begin
              addr_q[15:8] <= rx_shift;
              state        <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            if (rx_valid) begin
              addr_q[7:0] <= rx_shift;
              if (op_write) begin
                state <= S_DATA;
              end else begin
                state         <= S_WB_REQ;
                wbm.wbm_cyc_o <= 1'b1;
                wbm.wbm_stb_o <= 1'b1;
                wbm.wbm_we_o  <= 1'b0;
                wbm.wbm_sel_o <= 4'b0000;
                wbm.wbm_adr_o <= 32'(lo_addr[ADDR_W-1:0]);
                wbm.wbm_dat_o <= '0;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              state         <= S_WB_REQ;
              wbm.wbm_cyc_o <= 1'b1;
              wbm.wbm_stb_o <= 1'b1;
              wbm.wbm_we_o  <= 1'b1;
              wbm.wbm_sel_o <= 4'b0001;
              wbm.wbm_adr_o <= 32'(addr_q[ADDR_W-1:0]);
              wbm.wbm_dat_o <= {4{rx_shift}};
            end
          end
          S_WB_REQ: begin
            if (wbm.wbm_ack_i) begin
              state         <= S_RESP;
              resp_q        <= op_write ? RESP_OK : wbm.wbm_dat_i[7:0];
              wbm.wbm_cyc_o <= 1'b0;
              wbm.wbm_stb_o <= 1'b0;
              wbm.wbm_we_o  <= 1'b0;
              wbm.wbm_sel_o <= '0;
              wbm.wbm_adr_o <= '0;
              wbm.wbm_dat_o <= '0;
            end
`ifdef WB_TIMEOUT_EN
            else if (to_cnt == 8'd254) begin
              // 255th cycle without ack: give up and report
              state         <= S_RESP;
              resp_q        <= RESP_TO;
              wbm.wbm_cyc_o <= 1'b0;
              wbm.wbm_stb_o <= 1'b0;
              wbm.wbm_we_o  <= 1'b0;
              wbm.wbm_sel_o <= '0;
              wbm.wbm_adr_o <= '0;
              wbm.wbm_dat_o <= '0;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
`endif
          end
          S_RESP: begin
            // TX can still be finishing a frame if an earlier command was abandoned
            if (!tx_busy) begin
              tx_load <= 1'b1;
              state   <= S_TX_WAIT;
            end
          end
          S_TX_WAIT: begin
            if (tx_done) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
